multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core. It sequences the shared ALU, register file, instruction/data memory and PC across the cycles of each instruction.
- It drives aluOp to the ALUControl decoder, using the existing encoding: 00 = ADD, 01 = SUB, 10 = decode by funct3/funct7_5.
- It sits between the instruction register opcode field and the datapath mux/enable controls.
- It supports lw, sw, R-type, I-type ALU, beq and jal, with a memory-ready stall handshake.

Parameters:
- MEM_WAIT_EN, 1, when 1 memory states wait for memReady; when 0 memReady is ignored and treated as 1.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  instr[6:0] from the instruction register.
- zero  input  1  ALU zero flag.
- memReady  input  1  memory has completed the current access this cycle.
- pcWrite  output  1  PC load enable; equals (branch & zero) | pcUpdate.
- adrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
- memWrite  output  1  data memory write request.
- irWrite  output  1  instruction register and oldPC load enable.
- resultSrc  output  2  result mux select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- aluSrcA  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1 data.
- aluSrcB  output  2  ALU B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- aluOp  output  2  to ALUControl.
- regWrite  output  1  register file write enable.
- illegalInstr  output  1  one-cycle pulse on an unsupported opcode.
- instrRetired  output  1  one-cycle pulse in the last cycle of each completed instruction.
- stateOut  output  4  current state encoding, for debug.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10
  - codes 11-15 are unused; if ever reached, go to FETCH next cycle.
- Reset:
  - reset sampled high on a clk edge sets the state to FETCH.
  - While reset is high, all outputs are combinationally forced to 0, including stateOut. After release, stateOut shows 0 (FETCH).
  - Reset mid-instruction abandons the instruction: no write enable is asserted in the reset cycle, and no instrRetired pulse is produced.
- Moore outputs per state (any output not listed for a state is 0):
  - FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10; irWrite=pcUpdate=memReady. Stay in FETCH while memReady=0; go to DECODE when 1.
  - DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target precompute). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> FETCH, with illegalInstr=1 this cycle.
  - MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Next state MEMREAD if opcode=0000011, else MEMWRITE.
  - MEMREAD: adrSrc=1, resultSrc=00. Hold while memReady=0, then go to MEMWB.
  - MEMWB: resultSrc=01, regWrite=1, instrRetired=1. Next state FETCH.
  - MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1. memWrite stays high for every cycle spent in MEMWRITE. When memReady=1: instrRetired=1, next state FETCH.
  - EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10. Next state ALUWB.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10. Next state ALUWB.
  - ALUWB: resultSrc=00, regWrite=1, instrRetired=1. Next state FETCH.
  - BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1, so pcWrite=zero. instrRetired=1. Next state FETCH.
  - JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1. Next state ALUWB (writes the link address).
- pcWrite is the only output that depends on an input (zero) outside FETCH; all other outputs are decoded from state plus memReady.
- Latency with memReady tied to 1:
  - lw = 5 cycles
  - sw, R-type, I-type, jal = 4 cycles
  - beq = 3 cycles
  - illegal opcode = 2 cycles
- Each cycle of memReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- The opcode input is sampled only in DECODE and MEMADR; the IR is stable there because irWrite=0.

Test Plan:
- Reset held 3 cycles during MEMWRITE -> memWrite=0 throughout reset; stateOut=0 after release; no instrRetired pulse.
- lw (opcode 0000011), memReady=1 -> stateOut sequence 0,1,2,3,4; regWrite=1 and resultSrc=01 only in cycle 5; instrRetired pulses once.
- sw with memReady low for 2 cycles in MEMWRITE -> memWrite=1 for 3 consecutive cycles, then FETCH; regWrite never 1.
- beq: zero=1 -> pcWrite=1 in BEQ; zero=0 -> pcWrite=0; both cases return to FETCH after 3 cycles.
- jal -> sequence 0,1,10,8; pcWrite=1 in FETCH and JAL; regWrite=1 in ALUWB.
- R-type and I-type -> aluOp=10 in the execute state, with aluSrcB=00 and 01 respectively.
- Opcode 1111111 -> illegalInstr=1 for the single DECODE cycle; no write enables asserted; next state FETCH.
- FETCH with memReady=0 for 4 cycles -> irWrite=0 and pcWrite=0 during the stall; exactly one irWrite pulse.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences PC, memory, register file
// and the shared ALU across the cycles of lw, sw, R-type, I-type, beq and jal.
module multicycle_controller #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       memReady,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       irWrite,
   output logic [1:0] resultSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp,
   output logic       regWrite,
   output logic       illegalInstr,
   output logic       instrRetired,
   output logic [3:0] stateOut
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   state_t     r_state;
   state_t     w_next;
   logic       w_rdy;
   logic       w_branch;
   logic       w_pcUpdate;
   logic       w_adrSrc;
   logic       w_memWrite;
   logic       w_irWrite;
   logic [1:0] w_resultSrc;
   logic [1:0] w_aluSrcA;
   logic [1:0] w_aluSrcB;
   logic [1:0] w_aluOp;
   logic       w_regWrite;
   logic       w_illegal;
   logic       w_retired;

   assign w_rdy = MEM_WAIT_EN ? memReady : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_branch    = 1'b0;
      w_pcUpdate  = 1'b0;
      w_adrSrc    = 1'b0;
      w_memWrite  = 1'b0;
      w_irWrite   = 1'b0;
      w_resultSrc = 2'b00;
      w_aluSrcA   = 2'b00;
      w_aluSrcB   = 2'b00;
      w_aluOp     = 2'b00;
      w_regWrite  = 1'b0;
      w_illegal   = 1'b0;
      w_retired   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_aluSrcB   = 2'b10;
            w_resultSrc = 2'b10;
            w_irWrite   = w_rdy;
            w_pcUpdate  = w_rdy;
            if (w_rdy) w_next = S_DECODE;
         end
         S_DECODE: begin
            // ALU precomputes oldPC + imm so BEQ has the branch target in ALUOut
            w_aluSrcA = 2'b01;
            w_aluSrcB = 2'b01;
            case (opcode)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTER;
               OP_I:         w_next = S_EXECUTEI;
               OP_BEQ:       w_next = S_BEQ;
               OP_JAL:       w_next = S_JAL;
               default: begin
                  w_next    = S_FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            w_aluSrcA = 2'b10;
            w_aluSrcB = 2'b01;
            w_next    = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_adrSrc = 1'b1;
            if (w_rdy) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_resultSrc = 2'b01;
            w_regWrite  = 1'b1;
            w_retired   = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEMWRITE: begin
            w_adrSrc   = 1'b1;
            w_memWrite = 1'b1;
            if (w_rdy) begin
               w_retired = 1'b1;
               w_next    = S_FETCH;
            end
         end
         S_EXECUTER: begin
            w_aluSrcA = 2'b10;
            w_aluOp   = 2'b10;
            w_next    = S_ALUWB;
         end
         S_EXECUTEI: begin
            w_aluSrcA = 2'b10;
            w_aluSrcB = 2'b01;
            w_aluOp   = 2'b10;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            w_regWrite = 1'b1;
            w_retired  = 1'b1;
            w_next     = S_FETCH;
         end
         S_BEQ: begin
            w_aluSrcA = 2'b10;
            w_aluOp   = 2'b01;
            w_branch  = 1'b1;
            w_retired = 1'b1;
            w_next    = S_FETCH;
         end
         S_JAL: begin
            w_aluSrcA  = 2'b01;
            w_aluSrcB  = 2'b10;
            w_pcUpdate = 1'b1;
            w_next     = S_ALUWB;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Reset masks every output so an abandoned instruction cannot write anything
   assign pcWrite      = ~reset & ((w_branch & zero) | w_pcUpdate);
   assign adrSrc       = ~reset & w_adrSrc;
   assign memWrite     = ~reset & w_memWrite;
   assign irWrite      = ~reset & w_irWrite;
   assign resultSrc    = reset ? 2'b00 : w_resultSrc;
   assign aluSrcA      = reset ? 2'b00 : w_aluSrcA;
   assign aluSrcB      = reset ? 2'b00 : w_aluSrcB;
   assign aluOp        = reset ? 2'b00 : w_aluOp;
   assign regWrite     = ~reset & w_regWrite;
   assign illegalInstr = ~reset & w_illegal;
   assign instrRetired = ~reset & w_retired;
   assign stateOut     = reset ? 4'd0 : r_state;

endmodule
